// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM and its clear engine.
package sync_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/sync_dp_ram_if.sv
// Access bus of the simple-dual-port RAM: clear request, write port A, read port B, status.
interface sync_dp_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    clr_req;
  logic                    busy;
  logic                    a_cs;
  logic                    a_we;
  logic [DATA_WIDTH/8-1:0] a_be;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic                    b_cs;
  logic                    b_re;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [DATA_WIDTH-1:0]   b_rdata;
  logic                    b_rvalid;
  logic                    acc_drop;

  modport master (
    output clr_req, a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_re, b_addr,
    input  busy, b_rdata, b_rvalid, acc_drop
  );

  modport slave (
    input  clr_req, a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_re, b_addr,
    output busy, b_rdata, b_rvalid, acc_drop
  );
endinterface

// File: rtl/sync_ram_clear_fsm.sv
// Clear engine: walks every word address once, one per cycle, holding busy while it runs.
//   state    | meaning
//   ST_IDLE  | no clear running (start_q set = first clear word pending after reset)
//   ST_CLEAR | zeroing word cnt_q, advancing each cycle until DEPTH-1
module sync_ram_clear_fsm
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  start_q, start_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // The post-reset start writes word 0 on its first edge so the whole clear spans DEPTH busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          if (cnt_q == LAST) begin
            cnt_d = '0;
          end else begin
            state_d = ST_CLEAR;
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o     = start_q | (state_q == ST_CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sync_dp_ram.sv
// Simple-dual-port synchronous RAM: byte-enabled write port A, read port B with 1/2-cycle latency,
// selectable read-during-write behaviour and a built-in clear engine.
module sync_dp_ram
  import sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sync_dp_ram_if.slave  bus
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_req, rd_req, wr_ok, rd_ok, a_in_rng, b_in_rng;
  logic [DATA_WIDTH-1:0] rd_mem, wr_merged, rd_word;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  rv1_q, acc_drop_q, acc_drop_d;
  logic [DATA_WIDTH-1:0] rd1_q;

  sync_ram_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_req_i (bus.clr_req),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  assign bus.busy = busy;
  assign a_in_rng = {1'b0, bus.a_addr} < DEPTH_W;
  assign b_in_rng = {1'b0, bus.b_addr} < DEPTH_W;
  assign wr_req   = bus.a_cs & bus.a_we;
  assign rd_req   = bus.b_cs & bus.b_re;
  assign wr_ok    = wr_req & ~busy & a_in_rng;
  assign rd_ok    = rd_req & ~busy & b_in_rng;

  // wr_merged overlays port A bytes on the word port B is reading; only used when addresses match.
  always_comb begin
    rd_mem    = mem_q[bus.b_addr];
    wr_merged = rd_mem;
    for (int i = 0; i < NB; i++) begin
      if (bus.a_be[i]) wr_merged[8*i +: 8] = bus.a_wdata[8*i +: 8];
    end
    rd_word = rd_mem;
    if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && bus.a_addr == bus.b_addr) rd_word = wr_merged;
  end

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.a_be[i]) mem_q[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
      end
    end
  end

  assign acc_drop_d = (wr_req & (busy | ~a_in_rng)) | (rd_req & (busy | ~b_in_rng));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rv1_q      <= 1'b0;
      rd1_q      <= '0;
      acc_drop_q <= 1'b0;
    end else begin
      rv1_q      <= rd_ok;
      acc_drop_q <= acc_drop_d;
      if (rd_ok) rd1_q <= rd_word;
    end
  end

  assign bus.acc_drop = acc_drop_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  rv2_q;
    logic [DATA_WIDTH-1:0] rd2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rv2_q <= 1'b0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) rd2_q <= rd1_q;
      end
    end
    assign bus.b_rvalid = rv2_q;
    assign bus.b_rdata  = rd2_q;
  end else begin : g_lat1
    assign bus.b_rvalid = rv1_q;
    assign bus.b_rdata  = rd1_q;
  end

endmodule

// File: tb/tb_sync_dp_ram.sv
// Bench for sync_dp_ram: two instances (256/lat1/read-first, 200/lat2/write-first) fed identical stimulus.
module tb_sync_dp_ram;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int D0 = 256;
  localparam int D1 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clr_req, a_cs, a_we, b_cs, b_re;
  logic [3:0]    a_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata;

  sync_dp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  sync_dp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.clr_req = clr_req;  assign bus1.clr_req = clr_req;
  assign bus0.a_cs    = a_cs;     assign bus1.a_cs    = a_cs;
  assign bus0.a_we    = a_we;     assign bus1.a_we    = a_we;
  assign bus0.a_be    = a_be;     assign bus1.a_be    = a_be;
  assign bus0.a_addr  = a_addr;   assign bus1.a_addr  = a_addr;
  assign bus0.a_wdata = a_wdata;  assign bus1.a_wdata = a_wdata;
  assign bus0.b_cs    = b_cs;     assign bus1.b_cs    = b_cs;
  assign bus0.b_re    = b_re;     assign bus1.b_re    = b_re;
  assign bus0.b_addr  = b_addr;   assign bus1.b_addr  = b_addr;

  sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D0), .RD_LATENCY(1),
                .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));

  sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D1), .RD_LATENCY(2),
                .RDW_MODE(1), .CLEAR_ON_RESET(1))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  // Reference model: plain word arrays, a remaining-clear-cycles count and a result schedule by edge.
  int          depth_m [2] = '{D0, D1};
  int          lat_m   [2] = '{1, 2};
  int          rdw_m   [2] = '{0, 1};
  logic [31:0] mem_m   [2][256];
  int          clr_left[2];
  logic        sv      [2][4];
  logic [31:0] sd      [2][4];
  logic        exp_busy[2], exp_rv[2], exp_drop[2];
  logic [31:0] exp_rd  [2];
  int          ecnt = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = depth_m[k];
      for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
      exp_busy[k] = 1'b1;
      exp_rv[k]   = 1'b0;
      exp_rd[k]   = '0;
      exp_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          busy_now, wr, rd, wr_ok, rd_ok;
      logic [31:0] w;
      int          slot;
      busy_now = clr_left[k] > 0;
      wr    = a_cs && a_we;
      rd    = b_cs && b_re;
      wr_ok = wr && !busy_now && (int'(a_addr) < depth_m[k]);
      rd_ok = rd && !busy_now && (int'(b_addr) < depth_m[k]);
      if (rd_ok) begin
        w = mem_m[k][b_addr];
        if (rdw_m[k] == 1 && wr_ok && a_addr == b_addr) w = merge(w, a_wdata, a_be);
        slot = (ecnt + lat_m[k] - 1) % 4;
        sv[k][slot] = 1'b1;
        sd[k][slot] = w;
      end
      if (busy_now) begin
        mem_m[k][depth_m[k] - clr_left[k]] = '0;
        clr_left[k]--;
      end else if (clr_req) begin
        clr_left[k] = depth_m[k];
      end
      if (wr_ok) mem_m[k][a_addr] = merge(mem_m[k][a_addr], a_wdata, a_be);
      exp_drop[k] = (wr && !wr_ok) || (rd && !rd_ok);
      exp_busy[k] = clr_left[k] > 0;
      slot = ecnt % 4;
      exp_rv[k] = sv[k][slot];
      if (sv[k][slot]) exp_rd[k] = sd[k][slot];
      sv[k][slot] = 1'b0;
    end
    ecnt++;
  endtask

  task automatic check_all();
    cmp("busy0",  32'(bus0.busy),     32'(exp_busy[0]));
    cmp("rv0",    32'(bus0.b_rvalid), 32'(exp_rv[0]));
    cmp("rdata0", bus0.b_rdata,       exp_rd[0]);
    cmp("drop0",  32'(bus0.acc_drop), 32'(exp_drop[0]));
    cmp("busy1",  32'(bus1.busy),     32'(exp_busy[1]));
    cmp("rv1",    32'(bus1.b_rvalid), 32'(exp_rv[1]));
    cmp("rdata1", bus1.b_rdata,       exp_rd[1]);
    cmp("drop1",  32'(bus1.acc_drop), 32'(exp_drop[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    clr_req = 0; a_cs = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_cs = 0; b_re = 0; b_addr = '0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (n) @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  // Counts busy cycles right after reset release; bounded so a stuck busy still reaches the summary.
  task automatic count_clear(input string tag);
    int c0, c1;
    c0 = bus0.busy ? 1 : 0;
    c1 = bus1.busy ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus0.busy) c0++;
      if (bus1.busy) c1++;
    end
    cmp({tag, "_busy_cycles0"}, 32'(c0), 32'(D0));
    cmp({tag, "_busy_cycles1"}, 32'(c1), 32'(D1));
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 256; a++) begin
      idle_inputs();
      b_cs = 1; b_re = 1; b_addr = AW'(a);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  typedef struct {
    logic        a_wr;
    logic [3:0]  be;
    logic [7:0]  aa;
    logic [31:0] wd;
    logic        b_rd;
    logic [7:0]  ba;
    logic        rv0;
    logic [31:0] rd0;
    logic        drop0;
    logic        drop1;
  } vec_t;

  vec_t tbl [13];
  logic        rv_log [7];
  logic [31:0] rd_log [7];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 8'h05, 32'h11223344, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'h5, 8'h05, 32'hAABBCCDD, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h05, 1'b1, 32'h11BB33DD, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h10, 1'b1, 32'h00000000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h10, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 8'hC8, 32'h12345678, 1'b0, 8'h00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'hC8, 1'b1, 32'h12345678, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'hF, 8'hC7, 32'hCAFEF00D, 1'b0, 8'h00, 1'b0, 32'h12345678, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'hC7, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 8'hFF, 32'h0BADF00D, 1'b1, 8'hFE, 1'b1, 32'h00000000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 8'h05, 32'hFFFFFFFF, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h05, 1'b1, 32'h11BB33DD, 1'b0, 1'b0};

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem_m[k][a] = 'x;

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset(2);
    count_clear("por");
    read_sweep();

    // Directed table on the 256-deep latency-1 read-first instance; model checks both instances.
    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      a_cs = tbl[i].a_wr; a_we = tbl[i].a_wr; a_be = tbl[i].be;
      a_addr = tbl[i].aa; a_wdata = tbl[i].wd;
      b_cs = tbl[i].b_rd; b_re = tbl[i].b_rd; b_addr = tbl[i].ba;
      tick();
      cmp($sformatf("tbl%0d_rv0", i),    32'(bus0.b_rvalid), 32'(tbl[i].rv0));
      cmp($sformatf("tbl%0d_rd0", i),    bus0.b_rdata,       tbl[i].rd0);
      cmp($sformatf("tbl%0d_drop0", i),  32'(bus0.acc_drop), 32'(tbl[i].drop0));
      cmp($sformatf("tbl%0d_drop1", i),  32'(bus1.acc_drop), 32'(tbl[i].drop1));
    end

    // Latency-2 back-to-back reads of 0..3.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      a_cs = 1; a_we = 1; a_be = 4'hF; a_addr = AW'(i); a_wdata = 32'hA0 + 32'(i);
      tick();
    end
    for (int t = 0; t < 7; t++) begin
      idle_inputs();
      if (t < 4) begin
        b_cs = 1; b_re = 1; b_addr = AW'(t);
      end
      tick();
      rv_log[t] = bus1.b_rvalid;
      rd_log[t] = bus1.b_rdata;
    end
    for (int t = 0; t < 7; t++) begin
      cmp($sformatf("lat2_rv%0d", t), 32'(rv_log[t]), (t >= 1 && t <= 4) ? 32'd1 : 32'd0);
      if (t >= 1 && t <= 4) cmp($sformatf("lat2_rd%0d", t), rd_log[t], 32'hA0 + 32'(t - 1));
    end

    // Read-during-write on a zeroed word with a partial byte enable.
    idle_inputs();
    a_cs = 1; a_we = 1; a_be = 4'b0011; a_addr = 8'h30; a_wdata = 32'h55AA55AA;
    b_cs = 1; b_re = 1; b_addr = 8'h30;
    tick();
    cmp("rdw_first0", bus0.b_rdata, 32'h00000000);
    idle_inputs();
    tick();
    cmp("rdw_merged1", bus1.b_rdata, 32'h000055AA);
    repeat (2) tick();

    // Randomized traffic, mostly on a small address window to hit collisions.
    for (int i = 0; i < 500; i++) begin
      clr_req = ($urandom_range(0, 149) == 0);
      a_cs = $urandom_range(0, 3) != 0; a_we = $urandom_range(0, 1) != 0;
      a_be = 4'($urandom); a_wdata = $urandom;
      a_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
      b_cs = $urandom_range(0, 3) != 0; b_re = $urandom_range(0, 1) != 0;
      b_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    repeat (300) tick();

    // Reset 100 cycles into a requested clear, then a full restart.
    clr_req = 1;
    tick();
    idle_inputs();
    cmp("clr_busy0", 32'(bus0.busy), 32'd1);
    repeat (99) tick();
    do_reset(2);
    count_clear("abort");
    read_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
